// File: rtl/reg_file_dump.sv
// Debug-path register file dump engine: walks an index range through one read port
// and streams each word out over valid/ready with index, last tag and running checksum.
module reg_file_dump #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              areset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] first_idx,
    input  logic [ADDR_W-1:0] last_idx,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [DATA_W-1:0] rf_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_idx,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
    logic [ADDR_W-1:0] remaining_q, remaining_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [ADDR_W-1:0] out_idx_q, out_idx_d;
    logic              out_last_q, out_last_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] checksum_q, checksum_d;

    // NOTE: every flop is updated with <= so all state advances together on the edge.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state_q     <= S_IDLE;
            rf_addr_q   <= '0;
            remaining_q <= '0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            checksum_q  <= '0;
        end else begin
            state_q     <= state_d;
            rf_addr_q   <= rf_addr_d;
            remaining_q <= remaining_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
            checksum_q  <= checksum_d;
        end
    end

    // NOTE: hold-value defaults come first so no path through the case infers a latch.
    always_comb begin
        state_d     = state_q;
        rf_addr_d   = rf_addr_q;
        remaining_d = remaining_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        checksum_d  = checksum_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    rf_addr_d   = first_idx;
                    remaining_d = last_idx - first_idx;
                    checksum_d  = '0;
                    state_d     = S_LOAD;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    out_data_d  = rf_data;
                    out_idx_d   = rf_addr_q;
                    out_last_d  = (remaining_q == '0);
                    out_valid_d = 1'b1;
                    state_d     = S_SEND;
                end
            end
            S_SEND: begin
                // abort outranks a same-cycle handshake: the word in flight is not counted
                if (abort) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else if (out_ready) begin
                    checksum_d  = checksum_q + out_data_q;
                    out_valid_d = 1'b0;
                    if (out_last_q) begin
                        state_d = S_DONE;
                    end else begin
                        rf_addr_d   = rf_addr_q + ADDR_W'(1);
                        remaining_d = remaining_q - ADDR_W'(1);
                        state_d     = S_LOAD;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign rf_addr   = rf_addr_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign checksum  = checksum_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_reg_file_dump.sv
// Directed bench for reg_file_dump: a behavioural register file feeds the read port and
// each stream word, tag, checksum and status flag is compared against hand-derived values.
module tb_reg_file_dump;

    logic        clk;
    logic        areset;
    logic        start;
    logic        abort;
    logic [4:0]  first_idx;
    logic [4:0]  last_idx;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_idx;
    logic        out_last;
    logic        busy;
    logic        done;
    logic [31:0] checksum;

    logic [31:0] rf [32];

    int n_cmp = 0;
    int n_err = 0;

    reg_file_dump #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk       (clk),
        .areset    (areset),
        .start     (start),
        .abort     (abort),
        .first_idx (first_idx),
        .last_idx  (last_idx),
        .rf_addr   (rf_addr),
        .rf_data   (rf_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .checksum  (checksum)
    );

    assign rf_data = rf[rf_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        int c;
        c = 0;
        while (out_valid !== 1'b1 && c < 20) begin
            tick();
            c++;
        end
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
    endtask

    // Full dump with out_ready held high; expected words come from the rf model.
    task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input string tag,
                            output logic [31:0] sum);
        int         n;
        logic [4:0] idx;
        logic [4:0] span;
        span = l - f;
        n    = int'(span) + 1;
        sum  = '0;
        idx  = f;
        first_idx = f;
        last_idx  = l;
        start     = 1'b1;
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_busy_load"}, 32'(busy), 32'd1);
        for (int k = 0; k < n; k++) begin
            wait_valid(tag);
            check({tag, "_idx"}, 32'(out_idx), 32'(idx));
            check({tag, "_data"}, out_data, rf[idx]);
            check({tag, "_last"}, 32'(out_last), 32'(k == n - 1));
            sum = sum + rf[idx];
            tick();
            idx = idx + 5'd1;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_sum"}, checksum, sum);
        tick();
        check({tag, "_done_clr"}, 32'(done), 32'd0);
        check({tag, "_busy_clr"}, 32'(busy), 32'd0);
        check({tag, "_sum_hold"}, checksum, sum);
    endtask

    initial begin
        logic [31:0] sum;

        for (int i = 0; i < 32; i++) rf[i] = 32'h0101_0111 * 32'(i) + 32'hA500_0000;
        rf[0] = 32'h0;
        rf[1] = 32'h11;
        rf[2] = 32'h22;
        rf[3] = 32'h33;

        areset    = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        first_idx = '0;
        last_idx  = '0;
        out_ready = 1'b0;
        #12;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", checksum, 32'd0);
        check("rst_addr", 32'(rf_addr), 32'd0);
        areset = 1'b1;
        tick();

        // Basic three-word dump, checksum 0x11+0x22+0x33
        run_dump(5'd1, 5'd3, "t1", sum);
        check("t1_sum_const", checksum, 32'h66);

        // Wrap through 31 -> 0, x0 reads as zero
        run_dump(5'd30, 5'd1, "t2", sum);
        check("t2_sum_const", sum, rf[30] + rf[31] + 32'h0 + 32'h11);

        // Full 32-word sweep and single-word dump
        run_dump(5'd5, 5'd4, "t3_all", sum);
        run_dump(5'd7, 5'd7, "t3_one", sum);

        // Backpressure on word 2 of idx 10..13
        first_idx = 5'd10;
        last_idx  = 5'd13;
        start     = 1'b1;
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("t4_lat_valid", 32'(out_valid), 32'd1);
        check("t4_w1_idx", 32'(out_idx), 32'd10);
        tick();
        out_ready = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            check("t4_hold_valid", 32'(out_valid), 32'd1);
            check("t4_hold_idx", 32'(out_idx), 32'd11);
            check("t4_hold_data", out_data, rf[11]);
            check("t4_hold_sum", checksum, rf[10]);
            tick();
        end
        out_ready = 1'b1;
        check("t4_still_idx", 32'(out_idx), 32'd11);
        tick();
        check("t4_sum2", checksum, rf[10] + rf[11]);
        tick();
        check("t4_w3_idx", 32'(out_idx), 32'd12);
        tick();
        tick();
        check("t4_w4_idx", 32'(out_idx), 32'd13);
        check("t4_w4_last", 32'(out_last), 32'd1);
        tick();
        check("t4_done", 32'(done), 32'd1);
        check("t4_sum", checksum, rf[10] + rf[11] + rf[12] + rf[13]);
        tick();

        // Abort during word 2 of 20..23; a start while busy must be ignored
        first_idx = 5'd20;
        last_idx  = 5'd23;
        start     = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("t5_w1_idx", 32'(out_idx), 32'd20);
        tick();
        first_idx = 5'd0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        check("t5_w2_idx", 32'(out_idx), 32'd21);
        check("t5_w2_valid", 32'(out_valid), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5_abort_valid", 32'(out_valid), 32'd0);
        check("t5_abort_busy", 32'(busy), 32'd0);
        check("t5_abort_done", 32'(done), 32'd0);
        check("t5_abort_sum", checksum, rf[20]);
        tick();
        check("t5_idle_done", 32'(done), 32'd0);
        check("t5_idle_busy", 32'(busy), 32'd0);

        // start and abort together in IDLE: start wins; then abort from LOAD
        first_idx = 5'd8;
        last_idx  = 5'd9;
        start     = 1'b1;
        abort     = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("t5_start_wins", 32'(busy), 32'd1);
        check("t5_sum_clr", checksum, 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5_load_abort", 32'(busy), 32'd0);
        check("t5_load_abort_v", 32'(out_valid), 32'd0);

        // Asynchronous reset in the middle of SEND
        first_idx = 5'd2;
        last_idx  = 5'd5;
        start     = 1'b1;
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        out_ready = 1'b0;
        tick();
        check("t6_pre_valid", 32'(out_valid), 32'd1);
        check("t6_pre_sum", checksum, rf[2]);
        #2;
        areset = 1'b0;
        #1;
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_sum", checksum, 32'd0);
        check("t6_rst_data", out_data, 32'd0);
        check("t6_rst_idx", 32'(out_idx), 32'd0);
        check("t6_rst_last", 32'(out_last), 32'd0);
        check("t6_rst_addr", 32'(rf_addr), 32'd0);
        areset = 1'b1;
        tick();
        run_dump(5'd2, 5'd3, "t6_after", sum);
        check("t6_after_const", checksum, 32'h55);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
